// File: rtl/fir_mac_engine_pkg.sv
// Shared defaults, coefficient set and state type for the FIR MAC engine.
package fir_params;

  localparam int N_TAPS      = 16;
  localparam int IN_WIDTH    = 16;
  localparam int COEFF_WIDTH = 16;
  localparam int OUT_WIDTH   = 16;
  localparam int FRAC_BITS   = 15;

  // Symmetric Q1.15 low-pass; coefficient 0 sits in the most significant slot.
  localparam logic [N_TAPS*COEFF_WIDTH-1:0] FIR_COEFFS = {
    16'hFF38, 16'hFED4, 16'h0000, 16'h04B0, 16'h09C4, 16'h0FA0, 16'h1770, 16'h1F40,
    16'h1F40, 16'h1770, 16'h0FA0, 16'h09C4, 16'h04B0, 16'h0000, 16'hFED4, 16'hFF38
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_HOLD  = 2'd3
  } fir_mac_state_t;

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up and saturate from accumulator width down to output width.
module fir_round_sat #(
  parameter int ACC_WIDTH = 36,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic signed [OUT_WIDTH-1:0] data_o,
  output logic                        sat_o
);

  localparam int OFS_BIT = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic signed [ACC_WIDTH:0] ROUND_OFS =
    (FRAC_BITS > 0) ? ((ACC_WIDTH+1)'(1) <<< OFS_BIT) : '0;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] sum;
  logic signed [ACC_WIDTH:0] shifted;

  // One guard bit keeps the rounding offset from wrapping a near-full accumulator.
  assign sum     = {acc_i[ACC_WIDTH-1], acc_i} + ROUND_OFS;
  assign shifted = sum >>> FRAC_BITS;

  always_comb begin
    data_o = shifted[OUT_WIDTH-1:0];
    sat_o  = 1'b0;
    if (shifted > SAT_MAX) begin
      data_o = SAT_MAX[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      data_o = SAT_MIN[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// Serial FIR dot-product engine: one shared multiplier walks the captured window,
// then the result is rounded, saturated and held on a ready/valid output.
module fir_mac_engine #(
  parameter int N_TAPS      = fir_params::N_TAPS,
  parameter int IN_WIDTH    = fir_params::IN_WIDTH,
  parameter int COEFF_WIDTH = fir_params::COEFF_WIDTH,
  parameter int OUT_WIDTH   = fir_params::OUT_WIDTH,
  parameter int FRAC_BITS   = fir_params::FRAC_BITS,
  parameter int ACC_WIDTH   = IN_WIDTH + COEFF_WIDTH + $clog2(N_TAPS),
  parameter logic [N_TAPS*COEFF_WIDTH-1:0] COEFFS = fir_params::FIR_COEFFS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_TAPS*IN_WIDTH-1:0]  taps_in,
  input  logic                        taps_valid,
  output logic                        taps_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sat_flag,
  output logic                        overrun,
  output logic                        busy
);

  import fir_params::*;

  localparam int PROD_WIDTH = IN_WIDTH + COEFF_WIDTH;
  localparam int IDX_WIDTH  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_TAPS - 1);

  fir_mac_state_t                state_q, state_d;
  logic [N_TAPS*IN_WIDTH-1:0]    window_q, window_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [IDX_WIDTH-1:0]          idx_q, idx_d;
  logic signed [OUT_WIDTH-1:0]   outData_q, outData_d;
  logic                          outValid_q, outValid_d;
  logic                          satFlag_q, satFlag_d;
  logic                          overrun_q;

  logic signed [IN_WIDTH-1:0]    curTap;
  logic signed [COEFF_WIDTH-1:0] curCoeff;
  logic signed [PROD_WIDTH-1:0]  product;
  logic signed [OUT_WIDTH-1:0]   roundData;
  logic                          roundSat;
  logic                          tapsReady;

  assign curTap   = window_q[(N_TAPS-1-int'(idx_q))*IN_WIDTH +: IN_WIDTH];
  assign curCoeff = COEFFS[(N_TAPS-1-int'(idx_q))*COEFF_WIDTH +: COEFF_WIDTH];
  assign product  = curTap * curCoeff;

  // Ready never looks at taps_valid, so only overrun depends on the offered window.
  assign tapsReady = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);

  fir_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .acc_i  (acc_q),
    .data_o (roundData),
    .sat_o  (roundSat)
  );

  always_comb begin
    state_d    = state_q;
    window_d   = window_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    satFlag_d  = satFlag_q;
    unique case (state_q)
      ST_IDLE: begin
        if (taps_valid) begin
          window_d = taps_in;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + ACC_WIDTH'(product);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_ROUND;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_ROUND: begin
        outData_d  = roundData;
        satFlag_d  = roundSat;
        outValid_d = 1'b1;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          outValid_d = 1'b0;
          state_d    = ST_IDLE;
          if (taps_valid) begin
            window_d = taps_in;
            acc_d    = '0;
            idx_d    = '0;
            state_d  = ST_MAC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      window_q   <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      satFlag_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      satFlag_q  <= satFlag_d;
      overrun_q  <= taps_valid && !tapsReady;
    end
  end

  assign taps_ready = tapsReady;
  assign out_data   = outData_q;
  assign out_valid  = outValid_q;
  assign sat_flag   = satFlag_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fir_mac_engine.sv
// Scoreboard bench: three engines (default, all-max and tie-test coefficient sets)
// share inputs; expectations are queued at stimulus time and popped on each transfer.
module tb_fir_mac_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] tapsIn = '0;
  logic         outReady = 1'b1;
  logic         tv0 = 1'b0, tv1 = 1'b0, tv2 = 1'b0;

  logic        tr0, tr1, tr2, ov0, ov1, ov2, sf0, sf1, sf2;
  logic        or0, or1, or2, bz0, bz1, bz2;
  logic [15:0] od0, od1, od2;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int ovr0 = 0, ovr1 = 0, ovr2 = 0;
  int lastXfer0 = -1;
  bit b2bMode = 1'b0;

  logic [16:0] q0[$], q1[$], q2[$];

  // Hand-computed (32767*c_k + 16384) >>> 15; every |c_k| < 16384 so the result equals c_k.
  logic [15:0] EXP_IMP [16] = '{16'hFF38, 16'hFED4, 16'h0000, 16'h04B0,
                                16'h09C4, 16'h0FA0, 16'h1770, 16'h1F40,
                                16'h1F40, 16'h1770, 16'h0FA0, 16'h09C4,
                                16'h04B0, 16'h0000, 16'hFED4, 16'hFF38};

  fir_mac_engine dut0 (
    .clk(clk), .rst(rst), .taps_in(tapsIn), .taps_valid(tv0), .taps_ready(tr0),
    .out_data(od0), .out_valid(ov0), .out_ready(outReady), .sat_flag(sf0),
    .overrun(or0), .busy(bz0)
  );

  fir_mac_engine #(.COEFFS({16{16'h7FFF}})) dut1 (
    .clk(clk), .rst(rst), .taps_in(tapsIn), .taps_valid(tv1), .taps_ready(tr1),
    .out_data(od1), .out_valid(ov1), .out_ready(outReady), .sat_flag(sf1),
    .overrun(or1), .busy(bz1)
  );

  fir_mac_engine #(.COEFFS({16'h4000, {15{16'h0000}}})) dut2 (
    .clk(clk), .rst(rst), .taps_in(tapsIn), .taps_valid(tv2), .taps_ready(tr2),
    .out_data(od2), .out_valid(ov2), .out_ready(outReady), .sat_flag(sf2),
    .overrun(or2), .busy(bz2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic trOf(input int d);
    return (d == 0) ? tr0 : (d == 1) ? tr1 : tr2;
  endfunction

  function automatic logic ovOf(input int d);
    return (d == 0) ? ov0 : (d == 1) ? ov1 : ov2;
  endfunction

  function automatic logic bzOf(input int d);
    return (d == 0) ? bz0 : (d == 1) ? bz1 : bz2;
  endfunction

  function automatic logic [255:0] impulse(input int k, input logic [15:0] v);
    logic [255:0] w;
    w = '0;
    w[(16-k)*16-1 -: 16] = v;
    return w;
  endfunction

  task automatic setTv(input int d, input logic v);
    case (d)
      0: tv0 = v;
      1: tv1 = v;
      default: tv2 = v;
    endcase
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at cycle %0d", name, actual, expected, cycleCnt);
    end
  endtask

  task automatic checkOutput(input int d, input logic [15:0] data, input logic sat);
    logic [16:0] e;
    bit got;
    got = 1'b0;
    e = '0;
    case (d)
      0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
    endcase
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL unexpected_output dut%0d actual data=%h sat=%b required no transfer", d, data, sat);
    end else if ({sat, data} !== e) begin
      errors++;
      $display("[TB] FAIL out_dut%0d actual data=%h sat=%b required data=%h sat=%b",
               d, data, sat, e[15:0], e[16]);
    end
  endtask

  // Monitor: every accepted output is matched against the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov0 && outReady) begin
        checkOutput(0, od0, sf0);
        if (b2bMode) begin
          if (lastXfer0 >= 0) checkValue("b2b_spacing", 32'(cycleCnt - lastXfer0), 32'd18);
          lastXfer0 = cycleCnt;
        end
      end
      if (ov1 && outReady) checkOutput(1, od1, sf1);
      if (ov2 && outReady) checkOutput(2, od2, sf2);
      if (or0) ovr0++;
      if (or1) ovr1++;
      if (or2) ovr2++;
    end
  end

  task automatic waitReady(input int d);
    for (int i = 0; i < 200 && !trOf(d); i++) @(negedge clk);
    if (!trOf(d)) checkValue("ready_timeout", 32'(trOf(d)), 32'd1);
  endtask

  task automatic waitIdle(input int d);
    for (int i = 0; i < 200 && (ovOf(d) || bzOf(d)); i++) @(negedge clk);
    if (ovOf(d) || bzOf(d)) checkValue("idle_timeout", 32'(bzOf(d)), 32'd0);
  endtask

  task automatic applyStimulus(input int d, input logic [255:0] win, input logic [15:0] expData,
                               input logic expSat, input bit pushExp, input bit checkLat);
    if (pushExp) begin
      case (d)
        0: q0.push_back({expSat, expData});
        1: q1.push_back({expSat, expData});
        default: q2.push_back({expSat, expData});
      endcase
    end
    @(negedge clk);
    waitReady(d);
    tapsIn = win;
    setTv(d, 1'b1);
    @(posedge clk);
    #1;
    setTv(d, 1'b0);
    tapsIn = ~win;
    if (checkLat) begin
      repeat (16) @(posedge clk);
      #1 checkValue("latency_e16_valid", 32'(ovOf(d)), 32'd0);
      @(posedge clk);
      #1 checkValue("latency_e17_valid", 32'(ovOf(d)), 32'd1);
    end
  endtask

  initial begin
    int ovrBase;
    bit sawValid;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkValue("reset_taps_ready", 32'(tr0), 32'd1);
    checkValue("reset_out_valid", 32'(ov0), 32'd0);
    checkValue("reset_out_data", 32'(od0), 32'd0);
    checkValue("reset_sat_flag", 32'(sf0), 32'd0);
    checkValue("reset_overrun", 32'(or0), 32'd0);
    checkValue("reset_busy", 32'(bz0), 32'd0);

    $display("[TB] impulse responses");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, impulse(k, 16'h7FFF), EXP_IMP[k], 1'b0, 1'b1, 1'b1);
      waitIdle(0);
    end

    $display("[TB] saturation");
    applyStimulus(1, {16{16'h7FFF}}, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    waitIdle(1);
    applyStimulus(1, {16{16'h8000}}, 16'h8000, 1'b1, 1'b1, 1'b0);
    waitIdle(1);

    $display("[TB] rounding ties");
    applyStimulus(2, impulse(0, 16'h0001), 16'h0001, 1'b0, 1'b1, 1'b0);
    waitIdle(2);
    applyStimulus(2, impulse(0, 16'hFFFF), 16'h0000, 1'b0, 1'b1, 1'b0);
    waitIdle(2);
    applyStimulus(2, impulse(0, 16'hFFFD), 16'hFFFF, 1'b0, 1'b1, 1'b0);
    waitIdle(2);

    $display("[TB] backpressure and overrun");
    outReady = 1'b0;
    ovrBase = ovr0;
    applyStimulus(0, impulse(4, 16'h7FFF), 16'h09C4, 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    tapsIn = impulse(6, 16'h7FFF);
    tv0 = 1'b1;
    @(negedge clk);
    tv0 = 1'b0;
    for (int i = 0; i < 40 && !ov0; i++) @(negedge clk);
    checkValue("bp_valid_seen", 32'(ov0), 32'd1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checkValue("bp_hold_data", 32'(od0), 32'h09C4);
      checkValue("bp_hold_valid", 32'(ov0), 32'd1);
    end
    checkValue("bp_overrun_cycles", 32'(ovr0 - ovrBase), 32'd1);
    @(posedge clk);
    #1 outReady = 1'b1;
    waitIdle(0);
    repeat (20) @(negedge clk);
    checkValue("bp_valid_dropped", 32'(ov0), 32'd0);
    checkValue("bp_queue_drained", 32'(q0.size()), 32'd0);

    $display("[TB] back-to-back");
    ovrBase = ovr0;
    lastXfer0 = -1;
    b2bMode = 1'b1;
    applyStimulus(0, impulse(1, 16'h7FFF), 16'hFED4, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, impulse(3, 16'h7FFF), 16'h04B0, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, impulse(5, 16'h7FFF), 16'h0FA0, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, impulse(7, 16'h7FFF), 16'h1F40, 1'b0, 1'b1, 1'b0);
    waitIdle(0);
    b2bMode = 1'b0;
    checkValue("b2b_overrun", 32'(ovr0 - ovrBase), 32'd0);
    checkValue("b2b_queue_drained", 32'(q0.size()), 32'd0);

    $display("[TB] reset mid-computation");
    applyStimulus(0, impulse(2, 16'h7FFF), 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkValue("midrst_taps_ready", 32'(tr0), 32'd1);
    checkValue("midrst_busy", 32'(bz0), 32'd0);
    sawValid = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (ov0) sawValid = 1'b1;
    end
    checkValue("midrst_no_output", 32'(sawValid), 32'd0);
    applyStimulus(0, impulse(8, 16'h7FFF), 16'h1F40, 1'b0, 1'b1, 1'b1);
    waitIdle(0);

    repeat (5) @(negedge clk);
    checkValue("final_q0_empty", 32'(q0.size()), 32'd0);
    checkValue("final_q1_empty", 32'(q1.size()), 32'd0);
    checkValue("final_q2_empty", 32'(q2.size()), 32'd0);
    checkValue("final_overrun_dut1", 32'(ovr1), 32'd0);
    checkValue("final_overrun_dut2", 32'(ovr2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_engine.md
Name: fir_mac_engine

Overview:
- Consumer side of the FIR tap buffer.
- Accepts one packed window of N_TAPS samples per output, newest sample first.
- Computes the dot product against a coefficient set with one shared multiplier, iterating over N_TAPS cycles.
- Rounds and saturates the result, then presents it downstream on a ready/valid interface. It flags any window that arrives while the engine is busy.

Parameters:
- N_TAPS, 16, number of taps / coefficients.
- IN_WIDTH, 16, signed sample width.
- COEFF_WIDTH, 16, signed coefficient width (Q1.15 at default).
- OUT_WIDTH, 16, signed output width.
- FRAC_BITS, 15, right-shift applied after accumulation.
- ACC_WIDTH, IN_WIDTH+COEFF_WIDTH+$clog2(N_TAPS), accumulator width.
- COEFFS, FIR_COEFFS from package, packed N_TAPS*COEFF_WIDTH vector; coeff i at bits [(N_TAPS-i)*COEFF_WIDTH-1 -: COEFF_WIDTH].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- taps_in  in  N_TAPS*IN_WIDTH  signed window; tap i at [(N_TAPS-i)*IN_WIDTH-1 -: IN_WIDTH]; tap 0 newest.
- taps_valid  in  1  window offered.
- taps_ready  out  1  engine can accept a window this cycle.
- out_data  out  OUT_WIDTH  signed filtered sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- sat_flag  out  1  out_data was clipped; qualified by out_valid.
- overrun  out  1  one-cycle pulse: taps_valid seen while taps_ready low (window dropped).
- busy  out  1  state != IDLE.

Behaviour:
- Reset clock/reset: rst is synchronous, active-high; clk is the clock.
- Reset values: state=IDLE, acc=0, idx=0, out_data=0, out_valid=0, sat_flag=0, overrun=0. taps_ready=1 after reset.
- States: IDLE, MAC, ROUND, HOLD.
- IDLE:
  - taps_ready=1.
  - On taps_valid: capture taps_in into an internal window register, acc<=0, idx<=0, go to MAC.
- MAC:
  - Each cycle: acc <= acc + sext(tap[idx])*sext(coeff[idx]), idx++.
  - Product is signed IN_WIDTH+COEFF_WIDTH bits; the accumulator cannot overflow at ACC_WIDTH.
  - After the idx=N_TAPS-1 product, go to ROUND.
- ROUND (one cycle):
  - r = (acc + (1 <<< (FRAC_BITS-1))) >>> FRAC_BITS, arithmetic shift; round half toward +inf.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Register out_data, sat_flag, and out_valid<=1. Go to HOLD.
  - FRAC_BITS=0 means no rounding offset.
- HOLD:
  - out_valid=1; out_data and sat_flag held stable until out_ready.
  - On out_ready: out_valid<=0.
  - If taps_valid is also high in that cycle, accept the new window (taps_ready = out_ready in HOLD) and go to MAC. Otherwise go to IDLE.
- Latency: accept edge E0; MAC edges E1..E_N; out_valid high after edge E_(N_TAPS+1); 17 edges at default.
- Throughput: one window per N_TAPS+2 cycles with out_ready tied high (back-to-back via HOLD).
- taps_ready is combinational from state and out_ready. No combinational path from taps_valid to any output except overrun.
- overrun is registered; it asserts the cycle after any cycle where taps_valid=1 and taps_ready=0. The offered window is discarded, and the in-flight computation is unaffected.
- A window captured at E0 is held internally; changes on taps_in after E0 have no effect.
- rst mid-computation or in HOLD returns to IDLE next edge; out_valid drops, and the partial result is discarded (no output).

Decomposition:
- fir_params package/header:
  - Defaults N_TAPS, IN_WIDTH, COEFF_WIDTH, OUT_WIDTH, FRAC_BITS.
  - FIR_COEFFS packed constant.
  - State enum type fir_mac_state_t.
- Sub-module fir_round_sat: combinational ACC_WIDTH->OUT_WIDTH round+saturate, with a sat output. Reused by later output stages.

Test Plan:
- Impulse: default COEFFS; window with tap k=16'h7FFF, others 0, for each k=0..15 -> out_data=(32767*c_k+16384)>>>15. Out_valid rises exactly 17 edges after accept. sat_flag=0.
- Saturation: COEFFS all 16'h7FFF.
  - All taps 16'h7FFF -> out_data=16'h7FFF, sat_flag=1.
  - All taps 16'h8000 -> out_data=16'h8000, sat_flag=1.
- Rounding tie: COEFFS = coeff0=16'h4000, rest 0.
  - tap0=1 (acc=16384, r=(16384+16384)>>>15) -> out_data=1.
  - tap0=-1 (acc=-16384) -> out_data=0.
  - tap0=-3 (acc=-49152) -> out_data=-1.
- Backpressure/overrun:
  - out_ready=0 for 30 cycles after out_valid -> out_data stable.
  - Second taps_valid pulse during MAC -> overrun pulses one cycle, no extra output.
  - Release out_ready -> exactly one transfer.
- Back-to-back: taps_valid and out_ready held high, 4 distinct windows -> 4 correct outputs at 18-cycle spacing, no overrun.
- Reset mid-op: assert rst at MAC idx=7 for 1 cycle -> out_valid stays 0, taps_ready=1 next cycle; the next window yields a correct result.
